rbuf_rd: RTL



---
 rtl/rbuf_pkg.sv | 20 ++
 rtl/rbuf_rd_addr_gen.sv | 41 ++++
 rtl/rbuf_rd.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rbuf_pkg.sv
// Shared types and defaults for the sample ring buffer (write side rbuf, read side rbuf_rd).
package rbuf_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FIN
   } rd_state_e;

   localparam int DEF_M         = 4;
   localparam int DEF_ADDR_SIZE = 5;
   localparam int DEF_DATA_SIZE = 12;

   // Wide enough to hold m full-scale samples without overflow.
   function automatic int sum_width(input int data_size, input int m);
      return data_size + $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rbuf_rd_addr_gen.sv
// Loadable down-counter modulo M with a terminal-count flag (ptr == 0); reused for write-pointer wrap.
module rbuf_rd_addr_gen
   import rbuf_pkg::*;
#(
   parameter int M         = DEF_M,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [ADDR_SIZE-1:0] load_val,
   input  logic                 step,
   output logic [ADDR_SIZE-1:0] ptr,
   output logic                 tc
);

   localparam logic [ADDR_SIZE-1:0] TOP = ADDR_SIZE'(M - 1);

   logic [ADDR_SIZE-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (load) begin
         ptr_d = load_val;
      end else if (step) begin
         ptr_d = (ptr_q == '0) ? TOP : ptr_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;
   assign tc  = (ptr_q == '0);

endmodule

// File: rtl/rbuf_rd.sv
// Ring-buffer read side: streams the M newest samples newest-to-oldest from BRAM and reports their sum.
module rbuf_rd
   import rbuf_pkg::*;
#(
   parameter  int M         = DEF_M,
   parameter  int ADDR_SIZE = DEF_ADDR_SIZE,
   parameter  int DATA_SIZE = DEF_DATA_SIZE,
   parameter  int RD_LAT    = 1,
   localparam int SUM_W     = sum_width(DATA_SIZE, M)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_SIZE-1:0] head,
   output logic [ADDR_SIZE-1:0] addr,
   output logic                 ren,
   input  logic [DATA_SIZE-1:0] bram_do,
   output logic [DATA_SIZE-1:0] dout,
   output logic                 dout_valid,
   output logic                 dout_last,
   output logic [SUM_W-1:0]     sum,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam logic [ADDR_SIZE:0]   M_W      = (ADDR_SIZE + 1)'(M);
   localparam logic [ADDR_SIZE-1:0] LAST_CNT = ADDR_SIZE'(M - 1);

   rd_state_e            state_q, state_d;
   logic                 issue, load, cnt_tc, ptr_tc_unused;
   logic [ADDR_SIZE-1:0] ptr, cnt_unused;
   logic [RD_LAT-1:0]    vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
   logic [DATA_SIZE-1:0] dout_q, dout_d;
   logic                 dout_valid_q, dout_valid_d, dout_last_q, dout_last_d;
   logic [SUM_W-1:0]     acc_q, acc_d;
   logic                 err_q, err_d;

   assign issue = (state_q == ISSUE);

   rbuf_rd_addr_gen #(.M(M), .ADDR_SIZE(ADDR_SIZE)) u_ptr (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (head),
      .step     (issue),
      .ptr      (ptr),
      .tc       (ptr_tc_unused)
   );

   // Issue counter: loaded with M-1, reaches zero on the final read address.
   rbuf_rd_addr_gen #(.M(M), .ADDR_SIZE(ADDR_SIZE)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (LAST_CNT),
      .step     (issue),
      .ptr      (cnt_unused),
      .tc       (cnt_tc)
   );

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      err_d   = 1'b0;
      acc_d   = acc_q;
      if (dout_valid_q) begin
         acc_d = acc_q + SUM_W'(dout_q);
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               if ({1'b0, head} < M_W) begin
                  load    = 1'b1;
                  acc_d   = '0;
                  state_d = ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ISSUE:   if (cnt_tc) state_d = DRAIN;
         DRAIN:   if (dout_last_q) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Return path: read-enable and last-flag ride alongside the BRAM latency.
   always_comb begin
      vld_pipe_d[0]  = issue;
      last_pipe_d[0] = issue & cnt_tc;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_pipe_d[i]  = vld_pipe_q[i-1];
         last_pipe_d[i] = last_pipe_q[i-1];
      end
      dout_valid_d = vld_pipe_q[RD_LAT-1];
      dout_last_d  = last_pipe_q[RD_LAT-1];
      dout_d       = vld_pipe_q[RD_LAT-1] ? bram_do : dout_q;
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         vld_pipe_q   <= '0;
         last_pipe_q  <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         acc_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         vld_pipe_q   <= vld_pipe_d;
         last_pipe_q  <= last_pipe_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
         acc_q        <= acc_d;
         err_q        <= err_d;
      end
   end

   assign addr       = ptr;
   assign ren        = issue;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign dout_last  = dout_last_q;
   assign sum        = acc_q;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == FIN);
   assign err        = err_q;

endmodule
